// File: rtl/csr_trap_unit.sv
// csr_trap_unit: execute-stage machine-mode CSR file, CSR read-modify-write,
// ECALL trap entry, MRET/SRET return and a registered one-cycle fetch redirect.
// Optional build macro CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters.
module csr_trap_unit #(
    parameter int          XLEN        = 64,
    parameter logic [63:0] RESET_TVEC  = 64'h0000_0000,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic            stall,
    input  logic [9:0]      csr_decode,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal_csr,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_SEPC     = 12'h141;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

    typedef enum logic {RUN, REDIR} state_t;

    // decode bundle fields
    logic       ifecall, csr_alu_bsel, csr_we, if_csr;
    logic [1:0] csr_alu, csr_ret, csr_sel;
    logic [11:0] csr_addr;
    logic [4:0]  rs_field;
    assign {ifecall, csr_alu, csr_ret, csr_sel, csr_alu_bsel, csr_we, if_csr} = csr_decode;
    assign csr_addr = inst[31:20];
    assign rs_field = inst[19:15];

    // csr_sel does not influence the write value; low instruction bits and pc[1:0] are not needed
    logic unused_bits;
    assign unused_bits = ^{csr_sel, inst[14:0], pc[1:0]};

    state_t          state_reg;
    logic            redirect_valid_reg;
    logic [XLEN-1:0] redirect_pc_reg;
    logic            mie_reg, mpie_reg;
    logic [XLEN-1:0] mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, sepc_reg;
`ifdef CSR_COUNTERS_EN
    logic [63:0]     mcycle_reg, minstret_reg;
`endif

    logic            commit, do_ecall, do_mret, do_sret, csr_wen, implemented;
    logic [XLEN-1:0] csr_old, operand, csr_new, mstatus_val;

    assign mstatus_val = XLEN'({mpie_reg, 3'b000, mie_reg, 3'b000});

    // address decode and old-value read mux
    always_comb begin
        implemented = 1'b1;
        csr_old     = '0;
        case (csr_addr)
            ADDR_MSTATUS:  csr_old = mstatus_val;
            ADDR_MTVEC:    csr_old = mtvec_reg;
            ADDR_MSCRATCH: csr_old = mscratch_reg;
            ADDR_MEPC:     csr_old = mepc_reg;
            ADDR_MCAUSE:   csr_old = mcause_reg;
            ADDR_SEPC:     csr_old = sepc_reg;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:   csr_old = XLEN'(mcycle_reg);
            ADDR_MINSTRET: csr_old = XLEN'(minstret_reg);
`endif
            default:       implemented = 1'b0;
        endcase
    end

    assign illegal_csr = if_csr & ~implemented;
    assign csr_rdata   = implemented ? csr_old : '0;

    // read-modify-write value selected by csr_alu
    assign operand = csr_alu_bsel ? XLEN'(rs_field) : rs1_data;
    always_comb begin
        csr_new = csr_old;
        case (csr_alu)
            2'b00:   csr_new = operand;
            2'b01:   csr_new = csr_old | operand;
            2'b10:   csr_new = csr_old & ~operand;
            default: csr_new = csr_old;
        endcase
    end

    // ecall outranks ret, ret outranks a CSR op; set/clear with a zero source only reads
    assign commit   = in_valid & ~stall & (state_reg == RUN);
    assign do_ecall = commit & ifecall;
    assign do_mret  = commit & ~ifecall & (csr_ret[1]);
    assign do_sret  = commit & ~ifecall & (csr_ret == 2'b01);
    assign csr_wen  = commit & ~ifecall & (csr_ret == 2'b00) & if_csr & csr_we & ~illegal_csr
                      & ~((csr_alu != 2'b00) & (rs_field == 5'd0));

    // architectural CSR state: trap entry/return take precedence over software writes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mtvec_reg    <= {RESET_TVEC[XLEN-1:2], 2'b00};
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            sepc_reg     <= '0;
        end else if (do_ecall) begin
            mepc_reg   <= {pc[XLEN-1:2], 2'b00};
            mcause_reg <= XLEN'(ECALL_CAUSE);
            mpie_reg   <= mie_reg;
            mie_reg    <= 1'b0;
        end else if (do_mret) begin
            mie_reg  <= mpie_reg;
            mpie_reg <= 1'b1;
        end else if (csr_wen) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_reg  <= csr_new[3];
                    mpie_reg <= csr_new[7];
                end
                ADDR_MTVEC:    mtvec_reg    <= csr_new;
                ADDR_MSCRATCH: mscratch_reg <= csr_new;
                ADDR_MEPC:     mepc_reg     <= {csr_new[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_reg   <= csr_new;
                ADDR_SEPC:     sepc_reg     <= {csr_new[XLEN-1:2], 2'b00};
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // free-running counters; a software write in the same cycle wins over the increment
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            if (csr_wen && csr_addr == ADDR_MCYCLE)
                mcycle_reg <= 64'(csr_new);
            else
                mcycle_reg <= mcycle_reg + 64'd1;
            if (csr_wen && csr_addr == ADDR_MINSTRET)
                minstret_reg <= 64'(csr_new);
            else if (commit)
                minstret_reg <= minstret_reg + 64'd1;
        end
    end
`endif

    // redirect FSM: a committed ecall/ret produces exactly one registered redirect pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg          <= RUN;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    redirect_valid_reg <= 1'b0;
                    if (do_ecall) begin
                        state_reg          <= REDIR;
                        redirect_valid_reg <= 1'b1;
                        redirect_pc_reg    <= {mtvec_reg[XLEN-1:2], 2'b00};
                    end else if (do_mret) begin
                        state_reg          <= REDIR;
                        redirect_valid_reg <= 1'b1;
                        redirect_pc_reg    <= mepc_reg;
                    end else if (do_sret) begin
                        state_reg          <= REDIR;
                        redirect_valid_reg <= 1'b1;
                        redirect_pc_reg    <= sepc_reg;
                    end
                end
                default: begin
                    state_reg          <= RUN;
                    redirect_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed vector table for CSR ops plus hand-written
// trap/return/stall/reset sequences for csr_trap_unit.
module tb_csr_trap_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        stall;
    logic [9:0]  csr_decode;
    logic [31:0] inst;
    logic [63:0] rs1_data;
    logic [63:0] pc;
    logic [63:0] csr_rdata;
    logic        illegal_csr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int pass_cnt  = 0;
    int total_cnt = 0;

    csr_trap_unit #(.XLEN(64), .RESET_TVEC(64'h0), .ECALL_CAUSE(11)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .stall(stall),
        .csr_decode(csr_decode), .inst(inst), .rs1_data(rs1_data), .pc(pc),
        .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        st;
        logic [11:0] addr;
        logic [4:0]  rs;
        logic        bsel;
        logic [1:0]  alu;
        logic        we;
        logic [63:0] rs1d;
        logic [63:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic iv, logic st, logic [11:0] addr, logic [4:0] rs,
                                logic bsel, logic [1:0] alu, logic we, logic [63:0] rs1d,
                                logic [63:0] exp_rdata, logic exp_ill);
        vec_t v;
        v.iv = iv; v.st = st; v.addr = addr; v.rs = rs; v.bsel = bsel; v.alu = alu;
        v.we = we; v.rs1d = rs1d; v.exp_rdata = exp_rdata; v.exp_ill = exp_ill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // decode = {ifecall, alu[1:0], ret[1:0], sel[1:0], bsel, we, if_csr}
    task automatic drive(input logic iv, input logic st, input logic ec, input logic [1:0] alu,
                         input logic [1:0] ret, input logic bsel, input logic we, input logic ifc,
                         input logic [11:0] addr, input logic [4:0] rs, input logic [63:0] rs1d,
                         input logic [63:0] pcv);
        in_valid   = iv;
        stall      = st;
        csr_decode = {ec, alu, ret, 2'b00, bsel, we, ifc};
        inst       = {addr, rs, 15'h0};
        rs1_data   = rs1d;
        pc         = pcv;
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // csrrs x0 read: one cycle, checks old value and no redirect
    task automatic rd(input logic [11:0] addr, input logic [63:0] exp, input string nm);
        drive(1, 0, 0, 2'b01, 2'b00, 0, 1, 1, addr, 5'd0, 64'h0, 64'h0);
        @(negedge clk);
        chk(nm, csr_rdata, exp);
        chk({nm, " rv"}, {63'h0, redirect_valid}, 64'h0);
        tick();
    endtask

    task automatic csrrw(input logic [11:0] addr, input logic [63:0] val);
        drive(1, 0, 0, 2'b00, 2'b00, 0, 1, 1, addr, 5'd1, val, 64'h0);
        tick();
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 12'h305, 5'd0, 0, 2'b01, 1, 64'h0,      64'h0,      0);
        vecs[1]  = mk(1, 0, 12'h341, 5'd0, 0, 2'b01, 1, 64'h0,      64'h0,      0);
        vecs[2]  = mk(1, 0, 12'h340, 5'd1, 0, 2'b00, 1, 64'hDEAD,   64'h0,      0);
        vecs[3]  = mk(1, 0, 12'h340, 5'd0, 0, 2'b01, 1, 64'hFFFF,   64'hDEAD,   0);
        vecs[4]  = mk(1, 0, 12'h340, 5'd0, 0, 2'b01, 1, 64'h0,      64'hDEAD,   0);
        vecs[5]  = mk(1, 0, 12'h340, 5'd1, 0, 2'b01, 1, 64'hF0000,  64'hDEAD,   0);
        vecs[6]  = mk(1, 0, 12'h340, 5'd1, 0, 2'b10, 1, 64'hAD,     64'hFDEAD,  0);
        vecs[7]  = mk(1, 0, 12'h340, 5'd5, 1, 2'b00, 1, 64'hFFFF,   64'hFDE00,  0);
        vecs[8]  = mk(1, 0, 12'h340, 5'd0, 1, 2'b01, 1, 64'hFFFF,   64'h5,      0);
        vecs[9]  = mk(1, 0, 12'h340, 5'd3, 0, 2'b11, 1, 64'hFFFF,   64'h5,      0);
        vecs[10] = mk(1, 0, 12'h340, 5'd0, 0, 2'b01, 1, 64'h0,      64'h5,      0);
        vecs[11] = mk(1, 0, 12'h341, 5'd1, 0, 2'b00, 1, 64'h1237,   64'h0,      0);
        vecs[12] = mk(1, 0, 12'h341, 5'd0, 0, 2'b01, 1, 64'h0,      64'h1234,   0);
        vecs[13] = mk(1, 0, 12'h300, 5'd1, 0, 2'b00, 1, 64'hFFFF,   64'h0,      0);
        vecs[14] = mk(1, 0, 12'h300, 5'd0, 0, 2'b01, 1, 64'h0,      64'h88,     0);
        vecs[15] = mk(1, 0, 12'h300, 5'd1, 0, 2'b00, 1, 64'h0,      64'h88,     0);
        vecs[16] = mk(1, 0, 12'h300, 5'd0, 0, 2'b01, 1, 64'h0,      64'h0,      0);
        vecs[17] = mk(1, 0, 12'h7C0, 5'd1, 0, 2'b00, 1, 64'h55,     64'h0,      1);
        vecs[18] = mk(0, 0, 12'h340, 5'd1, 0, 2'b00, 1, 64'h99,     64'h5,      0);
        vecs[19] = mk(1, 1, 12'h340, 5'd1, 0, 2'b00, 1, 64'h77,     64'h5,      0);
        vecs[20] = mk(1, 0, 12'h340, 5'd0, 0, 2'b01, 1, 64'h0,      64'h5,      0);
        vecs[21] = mk(1, 0, 12'h141, 5'd1, 0, 2'b00, 1, 64'h2003,   64'h0,      0);
        vecs[22] = mk(1, 0, 12'h141, 5'd0, 0, 2'b01, 1, 64'h0,      64'h2000,   0);
        vecs[23] = mk(1, 0, 12'h342, 5'd1, 0, 2'b00, 1, 64'h7,      64'h0,      0);
        vecs[24] = mk(1, 0, 12'h342, 5'd0, 0, 2'b01, 1, 64'h0,      64'h7,      0);

        // reset
        rstn = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset rv", {63'h0, redirect_valid}, 64'h0);
        chk("reset rpc", redirect_pc, 64'h0);
        rstn = 1'b1;
        tick();

        // CSR op vector table
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].iv, vecs[i].st, 0, vecs[i].alu, 2'b00, vecs[i].bsel, vecs[i].we, 1,
                  vecs[i].addr, vecs[i].rs, vecs[i].rs1d, 64'h0);
            @(negedge clk);
            chk($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d illegal", i), {63'h0, illegal_csr}, {63'h0, vecs[i].exp_ill});
            chk($sformatf("vec%0d rv", i), {63'h0, redirect_valid}, 64'h0);
            tick();
        end

        // ECALL trap entry; a csrrw in the REDIR slot is dropped
        csrrw(12'h305, 64'h8000_0003);
        csrrw(12'h300, 64'h8);
        drive(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h1004);
        @(negedge clk);
        chk("ecall pre rv", {63'h0, redirect_valid}, 64'h0);
        tick();
        drive(1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 12'h340, 5'd1, 64'hBAD, 64'h0);
        @(negedge clk);
        chk("ecall rv", {63'h0, redirect_valid}, 64'h1);
        chk("ecall rpc", redirect_pc, 64'h8000_0000);
        tick();
        rd(12'h341, 64'h1004, "ecall mepc");
        rd(12'h342, 64'd11, "ecall mcause");
        rd(12'h300, 64'h80, "ecall mstatus");
        rd(12'h340, 64'h5, "ecall redir no write");

        // MRET
        drive(1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h0);
        tick();
        drive(1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 12'h340, 5'd1, 64'hBAD, 64'h0);
        @(negedge clk);
        chk("mret rv", {63'h0, redirect_valid}, 64'h1);
        chk("mret rpc", redirect_pc, 64'h1004);
        tick();
        rd(12'h300, 64'h88, "mret mstatus");
        rd(12'h340, 64'h5, "mret redir no write");

        // SRET
        drive(1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h0);
        tick();
        idle();
        @(negedge clk);
        chk("sret rv", {63'h0, redirect_valid}, 64'h1);
        chk("sret rpc", redirect_pc, 64'h2000);
        tick();
        rd(12'h300, 64'h88, "sret mstatus");

        // ECALL held by stall for 3 cycles, then one pulse even if stall returns in REDIR
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 2'b00, 2'b00, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h3000);
            @(negedge clk);
            chk($sformatf("stall%0d rv", i), {63'h0, redirect_valid}, 64'h0);
            tick();
        end
        drive(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h3000);
        @(negedge clk);
        chk("stall release rv", {63'h0, redirect_valid}, 64'h0);
        tick();
        drive(1, 1, 1, 2'b00, 2'b00, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h3000);
        @(negedge clk);
        chk("stall redir rv", {63'h0, redirect_valid}, 64'h1);
        chk("stall redir rpc", redirect_pc, 64'h8000_0000);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("stall post%0d rv", i), {63'h0, redirect_valid}, 64'h0);
            tick();
        end
        rd(12'h341, 64'h3000, "stall mepc");
        rd(12'h300, 64'h80, "stall mstatus");

        // back-to-back ECALL, then reset during the second REDIR
        drive(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h4000);
        tick();
        idle();
        @(negedge clk);
        chk("b2b first rv", {63'h0, redirect_valid}, 64'h1);
        tick();
        drive(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 12'h0, 5'd0, 64'h0, 64'h5000);
        @(negedge clk);
        chk("b2b gap rv", {63'h0, redirect_valid}, 64'h0);
        tick();
        idle();
        rstn = 1'b0;
        @(negedge clk);
        chk("b2b second rv", {63'h0, redirect_valid}, 64'h1);
        tick();
        @(negedge clk);
        chk("redir reset rv", {63'h0, redirect_valid}, 64'h0);
        chk("redir reset rpc", redirect_pc, 64'h0);
        rstn = 1'b1;
        tick();
        rd(12'h341, 64'h0, "post reset mepc");
        rd(12'h305, 64'h0, "post reset mtvec");

`ifdef CSR_COUNTERS_EN
        csrrw(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
        rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, "mcycle written");
        rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle max");
        rd(12'hB00, 64'h0, "mcycle wrap");
        csrrw(12'hB02, 64'd10);
        rd(12'hB02, 64'd10, "minstret written");
        rd(12'hB02, 64'd11, "minstret inc");
`else
        drive(1, 0, 0, 2'b01, 2'b00, 0, 1, 1, 12'hB00, 5'd0, 64'h0, 64'h0);
        @(negedge clk);
        chk("mcycle illegal", {63'h0, illegal_csr}, 64'h1);
        chk("mcycle rdata", csr_rdata, 64'h0);
        tick();
        drive(1, 0, 0, 2'b01, 2'b00, 0, 1, 1, 12'hB02, 5'd0, 64'h0, 64'h0);
        @(negedge clk);
        chk("minstret illegal", {63'h0, illegal_csr}, 64'h1);
        tick();
`endif

        idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
